// File: rtl/fetch_sched_pkg.sv
// Shared types and constants for the fetch sequencer.
// Imported by fetch_sched and its redirect selector.
package fetch_sched_pkg;

    localparam int          DEF_ADDR_W   = 32;
    localparam int          DEF_PKT_W    = 64;
    localparam logic [31:0] DEF_RESET_PC = 32'hbfc00000;
    localparam int          FETCH_BYTES  = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_EXC,
        CAUSE_BR
    } redir_cause_t;

endpackage

// File: rtl/fetch_redirect_sel.sv
// Priority select between exception and branch-repair redirects.
// Exceptions always win over branch repair.
module fetch_redirect_sel
    import fetch_sched_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              exc_redir,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              br_redir,
    input  logic [ADDR_W-1:0] br_pc,
    output logic              redir_valid,
    output logic [ADDR_W-1:0] redir_pc
);

    redir_cause_t cause;

    // pick the highest-priority redirect source
    always_comb begin
        cause    = CAUSE_NONE;
        redir_pc = '0;
        if (exc_redir) begin
            cause    = CAUSE_EXC;
            redir_pc = exc_pc;
        end else if (br_redir) begin
            cause    = CAUSE_BR;
            redir_pc = br_pc;
        end
        redir_valid = (cause != CAUSE_NONE);
    end

endmodule

// File: rtl/fetch_sched.sv
// Fetch sequencer: owns fetch PC and the icache handshake,
// drops packets made stale by redirects, feeds the ibuffer.
module fetch_sched
    import fetch_sched_pkg::*;
#(
    parameter int                RESET_PC_W = DEF_ADDR_W,
    parameter logic [RESET_PC_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                PKT_W    = DEF_PKT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_redir,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              br_redir,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic              bpu_valid,
    input  logic [ADDR_W-1:0] bpu_target,
    input  logic              bpu_dslot_in_pkt,
    input  logic              ibuf_full,
    output logic              icache_req,
    output logic [ADDR_W-1:0] icache_addr,
    input  logic              icache_addr_ok,
    input  logic              icache_data_ok,
    input  logic [PKT_W-1:0]  icache_rdata,
    output logic              ibuf_wr,
    output logic [ADDR_W-1:0] ibuf_pc,
    output logic [PKT_W-1:0]  ibuf_data,
    output logic [1:0]        ibuf_mask
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
    logic              pend_v, pend_v_nxt;
    logic [ADDR_W-1:0] pend_pc, pend_pc_nxt;
    logic              hold_v, hold_v_nxt;
    logic [ADDR_W-1:0] hold_pc, hold_pc_nxt;

    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] pkt_base;
    logic [ADDR_W-1:0] seq_pc;

    fetch_redirect_sel #(
        .ADDR_W(ADDR_W)
    ) u_sel (
        .exc_redir  (exc_redir),
        .exc_pc     (exc_pc),
        .br_redir   (br_redir),
        .br_pc      (br_pc),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc)
    );

    assign pkt_base    = {fetch_pc[ADDR_W-1:3], 3'b000};
    assign seq_pc      = pkt_base + ADDR_W'(FETCH_BYTES);
    assign icache_addr = pkt_base;
    assign ibuf_pc     = fetch_pc;
    assign ibuf_data   = icache_rdata;
    assign ibuf_mask   = fetch_pc[2] ? 2'b10 : 2'b11;

    // state and PC registers; reset drops everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= ADDR_W'(RESET_PC);
            pend_v   <= 1'b0;
            pend_pc  <= '0;
            hold_v   <= 1'b0;
            hold_pc  <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            pend_v   <= pend_v_nxt;
            pend_pc  <= pend_pc_nxt;
            hold_v   <= hold_v_nxt;
            hold_pc  <= hold_pc_nxt;
        end
    end

    // next state, next fetch PC and handshake outputs
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        pend_v_nxt   = pend_v;
        pend_pc_nxt  = pend_pc;
        hold_v_nxt   = hold_v;
        hold_pc_nxt  = hold_pc;
        icache_req   = 1'b0;
        ibuf_wr      = 1'b0;

        if (redir_valid) begin
            hold_v_nxt = 1'b0;
        end

        unique case (state)
            S_IDLE: begin
                if (redir_valid) begin
                    fetch_pc_nxt = redir_pc;
                end else if (!ibuf_full) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                icache_req = 1'b1;
                if (icache_addr_ok) begin
                    pend_v_nxt = 1'b0;
                    if (redir_valid) begin
                        fetch_pc_nxt = redir_pc;
                        state_nxt    = S_DROP;
                    end else if (pend_v) begin
                        fetch_pc_nxt = pend_pc;
                        state_nxt    = S_DROP;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end else if (redir_valid) begin
                    // address must stay stable; apply after acceptance
                    pend_v_nxt  = 1'b1;
                    pend_pc_nxt = redir_pc;
                end
            end
            S_WAIT: begin
                if (redir_valid) begin
                    fetch_pc_nxt = redir_pc;
                    state_nxt    = icache_data_ok ? S_IDLE : S_DROP;
                end else if (icache_data_ok) begin
                    ibuf_wr   = 1'b1;
                    state_nxt = S_IDLE;
                    if (hold_v) begin
                        fetch_pc_nxt = hold_pc;
                        hold_v_nxt   = 1'b0;
                    end else if (bpu_valid && bpu_dslot_in_pkt) begin
                        fetch_pc_nxt = bpu_target;
                    end else begin
                        fetch_pc_nxt = seq_pc;
                        if (bpu_valid) begin
                            // delay slot is in the next packet
                            hold_v_nxt  = 1'b1;
                            hold_pc_nxt = bpu_target;
                        end
                    end
                end
            end
            S_DROP: begin
                if (redir_valid) begin
                    fetch_pc_nxt = redir_pc;
                end
                if (icache_data_ok) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_sched.sv
// Randomized bench for fetch_sched against a
// transaction-level model of fetch requests and packet writes.
module tb_fetch_sched;

    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_redir;
    logic [31:0] exc_pc;
    logic        br_redir;
    logic [31:0] br_pc;
    logic        bpu_valid;
    logic [31:0] bpu_target;
    logic        bpu_dslot_in_pkt;
    logic        ibuf_full;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_addr_ok;
    logic        icache_data_ok;
    logic [63:0] icache_rdata;
    logic        ibuf_wr;
    logic [31:0] ibuf_pc;
    logic [63:0] ibuf_data;
    logic [1:0]  ibuf_mask;

    fetch_sched dut (
        .clk             (clk),
        .rst             (rst),
        .exc_redir       (exc_redir),
        .exc_pc          (exc_pc),
        .br_redir        (br_redir),
        .br_pc           (br_pc),
        .bpu_valid       (bpu_valid),
        .bpu_target      (bpu_target),
        .bpu_dslot_in_pkt(bpu_dslot_in_pkt),
        .ibuf_full       (ibuf_full),
        .icache_req      (icache_req),
        .icache_addr     (icache_addr),
        .icache_addr_ok  (icache_addr_ok),
        .icache_data_ok  (icache_data_ok),
        .icache_rdata    (icache_rdata),
        .ibuf_wr         (ibuf_wr),
        .ibuf_pc         (ibuf_pc),
        .ibuf_data       (ibuf_data),
        .ibuf_mask       (ibuf_mask)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // model: architectural next PC, pending BPU target, live request
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    logic [31:0] m_hold;
    bit          m_hold_v;
    bit          m_live;
    bit          m_acc;
    bit          m_poison;
    bit          m_start_due;
    bit          seen_zero;

    int p_redir, p_full, p_bpu, p_ack;

    function automatic logic [31:0] align8(input logic [31:0] a);
        return a & 32'hffff_fff8;
    endfunction

    task automatic model_reset();
        m_pc        = RST_PC;
        m_req_pc    = RST_PC;
        m_hold      = '0;
        m_hold_v    = 0;
        m_live      = 0;
        m_acc       = 0;
        m_poison    = 0;
        m_start_due = 0;
    endtask

    task automatic drive_idle();
        exc_redir        = 0;
        exc_pc           = '0;
        br_redir         = 0;
        br_pc            = '0;
        bpu_valid        = 0;
        bpu_target       = '0;
        bpu_dslot_in_pkt = 0;
        ibuf_full        = 0;
        icache_addr_ok   = 0;
        icache_data_ok   = 0;
        icache_rdata     = '0;
    endtask

    task automatic drive();
        bit r;
        r = ($urandom_range(99) < p_redir);
        exc_redir = r && ($urandom_range(1) == 1);
        br_redir  = r && (!exc_redir || $urandom_range(1) == 1);
        exc_pc    = $urandom & 32'hffff_fffc;
        br_pc     = $urandom & 32'hffff_fffc;
        ibuf_full = ($urandom_range(99) < p_full);
        icache_addr_ok = icache_req && ($urandom_range(99) < p_ack);
        icache_data_ok = m_live && m_acc && ($urandom_range(99) < p_ack);
        icache_rdata   = {$urandom, $urandom};
        bpu_valid        = ($urandom_range(99) < p_bpu);
        bpu_target       = $urandom & 32'hffff_fffc;
        bpu_dslot_in_pkt = ($urandom_range(1) == 1);
    endtask

    task automatic sample();
        bit          redir;
        bit          wr_exp;
        bit          idle_now;
        logic [31:0] tgt;
        if (rst) begin
            model_reset();
            check("rst_req", icache_req, 0);
            check("rst_wr", ibuf_wr, 0);
            check("rst_addr", icache_addr, RST_PC);
            return;
        end
        if (!m_live && m_start_due) begin
            m_live   = 1;
            m_acc    = 0;
            m_poison = 0;
            m_req_pc = m_pc;
        end
        idle_now = !m_live;
        check("req", icache_req, m_live && !m_acc);
        if (m_live && !m_acc) begin
            check("addr", icache_addr, align8(m_req_pc));
            if (icache_addr == 32'h0) seen_zero = 1;
        end
        redir  = exc_redir || br_redir;
        tgt    = exc_redir ? exc_pc : br_pc;
        wr_exp = icache_data_ok && m_live && m_acc && !m_poison && !redir;
        check("wr", ibuf_wr, wr_exp);
        if (wr_exp) begin
            check("pc", ibuf_pc, m_req_pc);
            check("data", ibuf_data, icache_rdata);
            check("mask", ibuf_mask, m_req_pc[2] ? 2'b10 : 2'b11);
        end
        if (redir) begin
            m_pc     = tgt;
            m_hold_v = 0;
            if (m_live) m_poison = 1;
        end else if (wr_exp) begin
            if (m_hold_v) begin
                m_pc     = m_hold;
                m_hold_v = 0;
            end else if (bpu_valid && bpu_dslot_in_pkt) begin
                m_pc = bpu_target;
            end else begin
                m_pc = align8(m_pc) + 32'd8;
                if (bpu_valid) begin
                    m_hold_v = 1;
                    m_hold   = bpu_target;
                end
            end
        end
        if (m_live && !m_acc && icache_addr_ok) m_acc = 1;
        else if (m_live && m_acc && icache_data_ok) m_live = 0;
        m_start_due = idle_now && !ibuf_full && !redir;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            drive();
            @(negedge clk);
            sample();
        end
    endtask

    initial begin
        bit found;
        rst = 1;
        seen_zero = 0;
        drive_idle();
        model_reset();
        p_redir = 0;
        p_full  = 0;
        p_bpu   = 0;
        p_ack   = 100;
        repeat (3) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            sample();
        end
        @(posedge clk);
        #1;
        rst = 0;
        drive();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        check("first_req", {icache_req, icache_addr}, {1'b1, RST_PC});
        sample();
        run(40);

        p_bpu = 40;
        run(300);
        p_redir = 15;
        run(400);
        p_full = 60;
        run(300);
        p_ack   = 40;
        p_redir = 10;
        run(500);

        // wrap from the top of the address space
        p_redir = 0;
        p_full  = 0;
        p_bpu   = 0;
        p_ack   = 100;
        @(posedge clk);
        #1;
        drive();
        exc_redir = 1;
        exc_pc    = 32'hffff_fff8;
        @(negedge clk);
        sample();
        run(30);
        check("wrap_seen", seen_zero, 1);

        // asynchronous reset with a request in flight
        p_ack = 30;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            run(1);
            found = m_live && m_acc;
        end
        check("reach_wait", found, 1);
        @(posedge clk);
        #1;
        drive();
        rst = 1;
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        rst = 0;
        p_ack = 100;
        drive();
        @(negedge clk);
        sample();
        run(1);
        p_redir = 8;
        p_full  = 30;
        p_bpu   = 40;
        p_ack   = 60;
        run(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
